// File: rtl/pc_sequencer_if.sv
// Purpose : bundles the fetch/commit handshake and PC outputs of pc_sequencer.
// Ports   : master = datapath/memory side (drives PCSrc, PC_Target, halt, imem_ready);
//           slave  = pc_sequencer (drives imem_req, PC, PC_Plus_4, instr_valid, retired, misalign).
interface pc_sequencer_if;
    logic        PCSrc;
    logic [31:0] PC_Target;
    logic        halt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] PC;
    logic [31:0] PC_Plus_4;
    logic        instr_valid;
    logic [31:0] retired;
    logic        misalign;

    modport master (
        output PCSrc, PC_Target, halt, imem_ready,
        input  imem_req, PC, PC_Plus_4, instr_valid, retired, misalign
    );

    modport slave (
        input  PCSrc, PC_Target, halt, imem_ready,
        output imem_req, PC, PC_Plus_4, instr_valid, retired, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose : program counter sequencer; IDLE -> FETCH (wait on imem_ready) -> HALTED.
// Latency : instr_valid is combinational with imem_ready; PC/retired update at the commit edge.
// Backpressure: imem_ready=0 holds PC and the fetch request; halt on commit stops fetching until reset.
// Ports   : clk, reset (sync, active-high), bus (pc_sequencer_if.slave).
// Config  : define PC_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VECTOR;
//           otherwise redirect targets are word-aligned and misalign stays 0.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        commit;
    logic        fetch_req;
    logic        target_misaligned;
    logic        trap;
    logic [31:0] pc_q;
    logic [31:0] pc_plus_4;
    logic [31:0] pc_nxt;
    logic [31:0] retired_q;
    logic        misalign_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (commit && bus.halt) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; reset gates the request so nothing commits while reset is held,
    // even when the state register still says FETCH.
    always_comb begin
        fetch_req = 1'b0;
        if (state == FETCH && !reset) fetch_req = 1'b1;
        commit = fetch_req && bus.imem_ready;
    end

    assign pc_plus_4         = pc_q + 32'd4;
    assign target_misaligned = (bus.PC_Target[1:0] != 2'b00);
    // Only a taken redirect can trap; a misaligned target on the fall-through path is ignored.
    assign trap              = TRAP_EN && bus.PCSrc && target_misaligned;

    always_comb begin
        pc_nxt = pc_plus_4;
        if (bus.PCSrc) begin
            if (trap) pc_nxt = TRAP_VECTOR;
            else      pc_nxt = {bus.PC_Target[31:2], 2'b00};
        end
    end

    // PC, retire counter and misalign pulse; all frozen outside of a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            retired_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= commit && trap;
            if (commit) begin
                pc_q      <= pc_nxt;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign bus.imem_req    = fetch_req;
    assign bus.instr_valid = commit;
    assign bus.PC          = pc_q;
    assign bus.PC_Plus_4   = pc_plus_4;
    assign bus.retired     = retired_q;
    assign bus.misalign    = misalign_q;

endmodule
